keypad_scanner: RTL
===================

# keypad_scanner

Scans a 4x4 matrix keypad (Pmod KYPD layout) by driving one column low at a time and sampling the rows. It debounces across whole scans and reports each new key press as a 4-bit hex code with a one-cycle strobe. This is the input-side counterpart of the multiplexed seven-segment display driver: a time-multiplexed scan that reads a matrix instead of writing one. It runs on the same slowed scan clock domain, and its codes feed the display digit registers.

## Interface
Parameters:
- SETTLE_CYCLES, 4: scan_clk cycles each column is driven before rows are sampled; minimum 3.
- DEBOUNCE_SCANS, 3: number of consecutive identical full-scan results required to accept a press or a release; range 1..15.

Ports:
- scan_clk  input  1  block clock.
- reset  input  1  synchronous, active-high reset.
- row  input  [3:0]  keypad rows, active-low, pulled up externally, asynchronous to scan_clk.
- col  output  [3:0]  keypad column drive, active-low, one-hot-low.
- key_code  output  [3:0]  hex code of the last accepted key.
- key_valid  output  1  one-cycle strobe on each accepted press.
- key_held  output  1  high while the accepted key is considered pressed.
- sseg  output  [6:0]  present only with KEYPAD_SSEG_EN; see Configuration.

## Operation
- row passes through a 2-flop synchronizer (reset value 4'b1111). All row decisions use the synchronized value.
- Column counter c (0..3) and settle counter s (0..SETTLE_CYCLES-1). col = ~(4'b0001 << c).
- Sample cycle: s == SETTLE_CYCLES-1. On this cycle, each low synchronized row bit r counts as a hit at (r,c). On the next cycle c advances (wraps 3->0) and s clears.
- Key map, listed by row as col0..col3:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: 0 F E D
- Scan result is computed at the col3 sample cycle:
  - NONE: 0 hits.
  - SINGLE(code): exactly 1 hit.
  - MULTI: 2 or more hits.
  - The hit accumulators clear for the next scan.
- Stability counter (4 bits, saturating at DEBOUNCE_SCANS):
  - Result equal to the previous scan's result (same class and, for SINGLE, same code): increment.
  - Otherwise: load 1.
- FSM states IDLE and PRESSED:
  - IDLE -> PRESSED when the result is SINGLE(k) and stability reaches DEBOUNCE_SCANS. key_code <= k, key_valid pulses, key_held <= 1.
  - PRESSED -> IDLE when the result is NONE and stability reaches DEBOUNCE_SCANS. key_held <= 0; key_code is retained.
  - In PRESSED, SINGLE of a different key or MULTI produces no event; the block stays PRESSED until a stable NONE.
  - In IDLE, a MULTI result never produces an event (ghosting rejection).
- Reset values: col = 4'b1110, c = 0, s = 0, key_code = 4'h0, key_valid = 0, key_held = 0, FSM = IDLE, stability = 0, previous result = NONE, accumulators cleared.
- Reset mid-scan or mid-press aborts everything. No key_valid is generated for a key held through reset until DEBOUNCE_SCANS fresh full scans have completed.

## Timing
- One full scan takes 4*SETTLE_CYCLES cycles (16 at defaults).
- key_valid and key_held update, registered, in the cycle after the qualifying col3 sample cycle. key_valid stays high for exactly 1 cycle.
- Press latency from the first scan that fully sees a stable key: DEBOUNCE_SCANS scans + 1 cycle. With defaults from reset, and the key pressed before reset releases: key_valid is high at cycle 48 after reset deasserts, with cycle 0 being the first cycle reset is low.
- Release latency: DEBOUNCE_SCANS scans of NONE + 1 cycle.
- The 2-flop synchronizer delay fits within SETTLE_CYCLES >= 3, so rows are never sampled from the previous column.

## Configuration
- KEYPAD_SSEG_EN defined: adds the registered output sseg[6:0] = {g,f,e,d,c,b,a}, active-low. It holds the hex glyph of key_code (e.g. 5 = 7'b0010010, d = 7'b0100001) while key_held = 1, and blanks (7'b1111111) otherwise. It updates in the same cycle as key_held. Reset value is 7'b1111111.
- KEYPAD_SSEG_EN undefined: the sseg port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, rows 4'b1111, run 100 cycles -> col cycles 1110, 1101, 1011, 0111 every 4 cycles. key_valid never asserts, key_held = 0, key_code = 4'h0.
- Hold key 5 (row1 low whenever col = 1101) from reset -> key_valid pulses once at cycle 48 with key_code = 4'h5 and key_held = 1. With KEYPAD_SSEG_EN, sseg = 7'b0010010.
- Key A present for only 2 scans, then released -> no key_valid, key_held stays 0.
- Keys 1 and 2 held together for 10 scans -> MULTI result, no key_valid, key_held = 0.
- Hold 7, then add 9 for 5 scans, then release both for 3 scans, then press D -> exactly one pulse with code 4'h7, key_held falls at the end of the 3rd NONE scan, then one pulse with code 4'hD.
- Assert reset for 1 cycle while 5 is held in PRESSED -> all outputs return to reset values next cycle; a new key_valid with code 4'h5 arrives 48 cycles after reset deasserts.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with whole-scan debouncing.
// Drives one column low at a time, samples the synchronized rows once they
// have settled, classifies each full scan (none / single key / multiple
// keys) and reports a stable single press as a hex code plus a strobe.
// Optional feature macro: KEYPAD_SSEG_EN adds the registered sseg output
// carrying the active-low hex glyph of the held key.
module keypad_scanner #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       scan_clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
`ifdef KEYPAD_SSEG_EN
  ,
  output logic [6:0] sseg
`endif
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [3:0] DEB_MAX = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {RES_NONE = 2'd0, RES_SINGLE = 2'd1, RES_MULTI = 2'd2} res_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_PRESSED = 1'b1} state_e;

  // Pmod KYPD legend, indexed by {row, column}.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  function automatic logic [2:0] hit_count(input logic [3:0] h);
    return 3'(h[0]) + 3'(h[1]) + 3'(h[2]) + 3'(h[3]);
  endfunction

  // Row index of a lone hit; only meaningful when exactly one bit is set.
  function automatic logic [1:0] hit_row(input logic [3:0] h);
    logic [1:0] r;
    case (h)
      4'b0010: r = 2'd1;
      4'b0100: r = 2'd2;
      4'b1000: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  logic [3:0]    sync1_r, sync2_r;
  logic [1:0]    col_idx_r;
  logic [SW-1:0] settle_r;
  logic [3:0]    col_r;
  logic [1:0]    acc_cnt_r;
  logic [3:0]    acc_code_r;
  res_e          prev_class_r;
  logic [3:0]    prev_code_r;
  logic [3:0]    stab_r;
  state_e        state_r, state_next_s;
  logic [3:0]    key_code_r, key_code_next_s;
  logic          key_valid_r, key_valid_next_s;
  logic          key_held_r, key_held_next_s;

  logic          sample_s, scan_done_s;
  logic [3:0]    hits_s;
  logic [2:0]    sample_cnt_s, total_cnt_s;
  logic [3:0]    sample_code_s, total_code_s;
  logic [1:0]    total_sat_s;
  res_e          res_class_s;
  logic          same_s;
  logic [3:0]    stab_next_s;

  // Two-flop synchronizer for the asynchronous, active-low rows.
  always_ff @(posedge scan_clk) begin
    if (reset) begin
      sync1_r <= 4'b1111;
      sync2_r <= 4'b1111;
    end else begin
      sync1_r <= row;
      sync2_r <= sync1_r;
    end
  end

  // Settle counter and rotating one-hot-low column drive.
  always_ff @(posedge scan_clk) begin
    if (reset) begin
      settle_r  <= '0;
      col_idx_r <= 2'd0;
      col_r     <= 4'b1110;
    end else if (sample_s) begin
      settle_r  <= '0;
      col_idx_r <= col_idx_r + 2'd1;
      col_r     <= {col_r[2:0], col_r[3]};
    end else begin
      settle_r  <= settle_r + SW'(1'b1);
    end
  end

  // Per-sample hit merge, scan classification and stability update.
  always_comb begin
    sample_s      = (settle_r == SETTLE_LAST);
    scan_done_s   = sample_s && (col_idx_r == 2'd3);
    hits_s        = ~sync2_r;
    sample_cnt_s  = hit_count(hits_s);
    sample_code_s = key_map(hit_row(hits_s), col_idx_r);
    total_cnt_s   = {1'b0, acc_cnt_r} + sample_cnt_s;
    if (total_cnt_s >= 3'd2) begin
      total_sat_s = 2'd2;
    end else begin
      total_sat_s = total_cnt_s[1:0];
    end
    if (acc_cnt_r == 2'd0) begin
      total_code_s = sample_code_s;
    end else begin
      total_code_s = acc_code_r;
    end
    case (total_sat_s)
      2'd0:    res_class_s = RES_NONE;
      2'd1:    res_class_s = RES_SINGLE;
      default: res_class_s = RES_MULTI;
    endcase
    same_s = (res_class_s == prev_class_r) &&
             ((res_class_s != RES_SINGLE) || (total_code_s == prev_code_r));
    if (!same_s) begin
      stab_next_s = 4'd1;
    end else if (stab_r >= DEB_MAX) begin
      stab_next_s = DEB_MAX;
    end else begin
      stab_next_s = stab_r + 4'd1;
    end
  end

  // Hit accumulator: merged on every sample, cleared when a scan completes.
  always_ff @(posedge scan_clk) begin
    if (reset) begin
      acc_cnt_r  <= 2'd0;
      acc_code_r <= 4'h0;
    end else if (scan_done_s) begin
      acc_cnt_r  <= 2'd0;
      acc_code_r <= 4'h0;
    end else if (sample_s) begin
      acc_cnt_r  <= total_sat_s;
      acc_code_r <= total_code_s;
    end else begin
      acc_cnt_r  <= acc_cnt_r;
      acc_code_r <= acc_code_r;
    end
  end

  // Previous scan result and stability count, updated once per scan.
  always_ff @(posedge scan_clk) begin
    if (reset) begin
      prev_class_r <= RES_NONE;
      prev_code_r  <= 4'h0;
      stab_r       <= 4'd0;
    end else if (scan_done_s) begin
      prev_class_r <= res_class_s;
      prev_code_r  <= total_code_s;
      stab_r       <= stab_next_s;
    end else begin
      prev_class_r <= prev_class_r;
      prev_code_r  <= prev_code_r;
      stab_r       <= stab_r;
    end
  end

  // Press/release FSM state and registered outputs.
  always_ff @(posedge scan_clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      key_code_r  <= 4'h0;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      key_code_r  <= key_code_next_s;
      key_valid_r <= key_valid_next_s;
      key_held_r  <= key_held_next_s;
    end
  end

  // Next state: accept a stable single press from IDLE, a stable release from PRESSED.
  always_comb begin
    state_next_s     = state_r;
    key_code_next_s  = key_code_r;
    key_valid_next_s = 1'b0;
    key_held_next_s  = key_held_r;
    if (scan_done_s && (stab_next_s == DEB_MAX)) begin
      case (state_r)
        ST_IDLE: begin
          if (res_class_s == RES_SINGLE) begin
            state_next_s     = ST_PRESSED;
            key_code_next_s  = total_code_s;
            key_valid_next_s = 1'b1;
            key_held_next_s  = 1'b1;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_PRESSED: begin
          if (res_class_s == RES_NONE) begin
            state_next_s    = ST_IDLE;
            key_held_next_s = 1'b0;
          end else begin
            state_next_s = ST_PRESSED;
          end
        end
        default: begin
          state_next_s    = ST_IDLE;
          key_held_next_s = 1'b0;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  assign col       = col_r;
  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;
  assign key_held  = key_held_r;

`ifdef KEYPAD_SSEG_EN
  // Active-low {g,f,e,d,c,b,a} hex glyphs.
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'b1000000;  4'h1: g = 7'b1111001;  4'h2: g = 7'b0100100;  4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;  4'h5: g = 7'b0010010;  4'h6: g = 7'b0000010;  4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;  4'h9: g = 7'b0010000;  4'hA: g = 7'b0001000;  4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;  4'hD: g = 7'b0100001;  4'hE: g = 7'b0000110;  4'hF: g = 7'b0001110;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  logic [6:0] sseg_r;

  // Glyph follows the held key in lockstep with key_held, blank otherwise.
  always_ff @(posedge scan_clk) begin
    if (reset) begin
      sseg_r <= 7'b1111111;
    end else if (key_held_next_s) begin
      sseg_r <= hex_glyph(key_code_next_s);
    end else begin
      sseg_r <= 7'b1111111;
    end
  end

  assign sseg = sseg_r;
`endif

endmodule
